// File: rtl/eth_pkg.sv
// Shared Ethernet MAC-control constants and helpers used by the PAUSE receive path.
// Byte indices refer to the position of a byte within the received frame, DA first.
package eth_pkg;

    localparam logic [47:0] PAUSE_MCAST_DA = 48'h0180C2000001;
    localparam logic [15:0] ETYPE_MAC_CTRL = 16'h8808;
    localparam logic [15:0] OPC_PAUSE      = 16'h0001;

    localparam logic [4:0] DA_END    = 5'd5;
    localparam logic [4:0] ETYPE_HI  = 5'd12;
    localparam logic [4:0] ETYPE_LO  = 5'd13;
    localparam logic [4:0] OPC_HI    = 5'd14;
    localparam logic [4:0] OPC_LO    = 5'd15;
    localparam logic [4:0] QUANTA_HI = 5'd16;
    localparam logic [4:0] QUANTA_LO = 5'd17;
    localparam logic [4:0] IDX_SAT   = 5'd18;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_QUANTA = 3'd2,
        ST_TAIL   = 3'd3,
        ST_DROP   = 3'd4
    } pause_state_e;

    // Byte idx (0..5) of a 48-bit MAC address in wire order.
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [4:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (idx == 5'(i)) begin
                b = addr[(5 - i) * 8 +: 8];
            end
        end
        return b;
    endfunction

    // Expected fixed byte for the ethertype/opcode positions 12..15.
    function automatic logic [7:0] ctrl_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            ETYPE_HI: b = ETYPE_MAC_CTRL[15:8];
            ETYPE_LO: b = ETYPE_MAC_CTRL[7:0];
            OPC_HI:   b = OPC_PAUSE[15:8];
            default:  b = OPC_PAUSE[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that keeps busy high for exactly load_value cycles after a load.
// Load has priority over the natural expiry so a reload in the final cycle never gaps busy.
module pause_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        busy
);

    logic [31:0] count_q, count_d;
    logic        busy_q, busy_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 32'd1;
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/pause_rx_detect.sv
// Receive-side 802.3x PAUSE decoder: parses the MAC rx byte stream, and on an accepted
// PAUSE frame holds the transmitter off for quanta * QUANTA_CYCLES clocks.
module pause_rx_detect
    import eth_pkg::*;
#(
    parameter int unsigned QUANTA_CYCLES = 64,
    parameter logic [47:0] STATION_ADDR  = 48'h000000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_err,
    output logic        tx_pause_hold,
    output logic [15:0] pause_quanta,
    output logic        pause_rcvd
);

    pause_state_e state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic         mc_ok_q, mc_ok_d;
    logic         st_ok_q, st_ok_d;
    logic         err_q, err_d;
    logic [15:0]  shadow_q, shadow_d;
    logic [15:0]  pause_quanta_q, pause_quanta_d;
    logic         pause_rcvd_q, pause_rcvd_d;

    logic         accept;
    logic         bad_frame;
    logic         hdr_ok;
    logic         mc_hit;
    logic         st_hit;
    logic [15:0]  quanta_val;
    logic [31:0]  timer_value;
    logic         timer_busy;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mc_ok_d    = mc_ok_q;
        st_ok_d    = st_ok_q;
        err_d      = err_q;
        shadow_d   = shadow_q;
        accept     = 1'b0;
        quanta_val = shadow_q;
        hdr_ok     = 1'b1;
        mc_hit     = 1'b0;
        st_hit     = 1'b0;
        bad_frame  = err_q | rx_err;

        if (rx_valid) begin
            idx_d = rx_last ? 5'd0 : ((idx_q == IDX_SAT) ? idx_q : idx_q + 5'd1);
            err_d = rx_last ? 1'b0 : bad_frame;

            unique case (state_q)
                ST_IDLE, ST_HDR: begin
                    if (idx_q <= DA_END) begin
                        // Both DA candidates are tracked in parallel; either surviving is enough.
                        mc_hit  = (idx_q == 5'd0 || mc_ok_q) &&
                                  (rx_data == addr_byte(PAUSE_MCAST_DA, idx_q));
                        st_hit  = (idx_q == 5'd0 || st_ok_q) &&
                                  (rx_data == addr_byte(STATION_ADDR, idx_q));
                        hdr_ok  = mc_hit | st_hit;
                        mc_ok_d = mc_hit;
                        st_ok_d = st_hit;
                    end else if (idx_q >= ETYPE_HI) begin
                        hdr_ok = (rx_data == ctrl_byte(idx_q));
                    end
                    if (!hdr_ok) begin
                        state_d = ST_DROP;
                    end else if (idx_q == OPC_LO) begin
                        state_d = ST_QUANTA;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_QUANTA: begin
                    if (idx_q == QUANTA_LO) begin
                        shadow_d[7:0] = rx_data;
                        quanta_val    = {shadow_q[15:8], rx_data};
                        accept        = rx_last & ~bad_frame;
                        state_d       = ST_TAIL;
                    end else begin
                        shadow_d[15:8] = rx_data;
                    end
                end
                ST_TAIL: begin
                    accept = rx_last & ~bad_frame;
                end
                default: begin
                end
            endcase

            if (rx_last) begin
                state_d = ST_IDLE;
            end
        end

        pause_quanta_d = accept ? quanta_val : pause_quanta_q;
        pause_rcvd_d   = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= 5'd0;
            mc_ok_q        <= 1'b0;
            st_ok_q        <= 1'b0;
            err_q          <= 1'b0;
            shadow_q       <= 16'h0000;
            pause_quanta_q <= 16'h0000;
            pause_rcvd_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mc_ok_q        <= mc_ok_d;
            st_ok_q        <= st_ok_d;
            err_q          <= err_d;
            shadow_q       <= shadow_d;
            pause_quanta_q <= pause_quanta_d;
            pause_rcvd_q   <= pause_rcvd_d;
        end
    end

    // A zero-quanta PAUSE is an XON: it clears the timer instead of loading it.
    assign timer_value = 32'(quanta_val) * 32'(QUANTA_CYCLES);

    pause_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept && (quanta_val == 16'h0000)),
        .load       (accept && (quanta_val != 16'h0000)),
        .load_value (timer_value),
        .busy       (timer_busy)
    );

    assign tx_pause_hold = timer_busy;
    assign pause_quanta  = pause_quanta_q;
    assign pause_rcvd    = pause_rcvd_q;

endmodule

// File: tb/tb_pause_rx_detect.sv
// Self-checking bench for pause_rx_detect: directed scenarios plus randomized frames,
// compared every cycle against a frame-level reference model.
module tb_pause_rx_detect;

    localparam int unsigned QC       = 64;
    localparam logic [47:0] MC_DA    = 48'h0180C2000001;
    localparam logic [47:0] STATION  = 48'h021122334455;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        tx_pause_hold;
    logic [15:0] pause_quanta;
    logic        pause_rcvd;

    int errors = 0;
    int checks = 0;

    pause_rx_detect #(
        .QUANTA_CYCLES (QC),
        .STATION_ADDR  (STATION)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_last       (rx_last),
        .rx_err        (rx_err),
        .tx_pause_hold (tx_pause_hold),
        .pause_quanta  (pause_quanta),
        .pause_rcvd    (pause_rcvd)
    );

    always #5 clk = ~clk;

    // Reference model: collect each frame's bytes, judge it whole on its last beat.
    logic [7:0]  m_buf[$];
    bit          m_err = 1'b0;
    bit          model_ok = 1'b0;
    longint      rem = 0;
    logic        exp_hold = 1'b0;
    logic [15:0] exp_q = 16'h0000;
    logic        exp_rcvd = 1'b0;
    logic [47:0] m_da;
    bit          m_acc;
    logic [15:0] m_qv;

    always @(posedge clk) begin
        if (rst) begin
            m_buf.delete();
            m_err    = 1'b0;
            rem      = 0;
            exp_hold = 1'b0;
            exp_q    = 16'h0000;
            exp_rcvd = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_acc = 1'b0;
            m_qv  = 16'h0000;
            if (rx_valid) begin
                if (m_buf.size() < 18) m_buf.push_back(rx_data);
                if (rx_err) m_err = 1'b1;
                if (rx_last) begin
                    if (m_buf.size() == 18 && !m_err) begin
                        m_da = '0;
                        for (int i = 0; i < 6; i++) m_da = {m_da[39:0], m_buf[i]};
                        m_acc = (m_da == MC_DA || m_da == STATION) &&
                                m_buf[12] == 8'h88 && m_buf[13] == 8'h08 &&
                                m_buf[14] == 8'h00 && m_buf[15] == 8'h01;
                        m_qv  = {m_buf[16], m_buf[17]};
                    end
                    m_buf.delete();
                    m_err = 1'b0;
                end
            end
            exp_rcvd = m_acc;
            if (m_acc) begin
                exp_q = m_qv;
                rem   = longint'(m_qv) * QC;
            end else if (rem > 0) begin
                rem--;
            end
            exp_hold = (rem > 0);
        end
    end

    // Per-cycle compare plus an event monitor used by the directed checks.
    int ncyc = 0;
    int rcvd_cnt = 0;
    int last_rcvd_n = 0;
    int falls = 0;
    int fall_n = 0;
    logic prev_hold = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (model_ok) begin
            checks += 3;
            if (pause_rcvd !== exp_rcvd) begin
                errors++;
                $display("FAIL cyc_pause_rcvd t=%0t got=%b exp=%b", $time, pause_rcvd, exp_rcvd);
            end
            if (pause_quanta !== exp_q) begin
                errors++;
                $display("FAIL cyc_pause_quanta t=%0t got=%h exp=%h", $time, pause_quanta, exp_q);
            end
            if (tx_pause_hold !== exp_hold) begin
                errors++;
                $display("FAIL cyc_tx_pause_hold t=%0t got=%b exp=%b", $time, tx_pause_hold, exp_hold);
            end
        end
        if (pause_rcvd === 1'b1) begin
            rcvd_cnt++;
            last_rcvd_n = ncyc;
        end
        if (prev_hold === 1'b1 && tx_pause_hold === 1'b0 && !rst) begin
            falls++;
            fall_n = ncyc;
        end
        prev_hold = tx_pause_hold;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0] fq[$];

    task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] opc,
                         input logic [15:0] q, input int pad);
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(da[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) fq.push_back(8'($urandom));
        fq.push_back(et[15:8]);
        fq.push_back(et[7:0]);
        fq.push_back(opc[15:8]);
        fq.push_back(opc[7:0]);
        fq.push_back(q[15:8]);
        fq.push_back(q[7:0]);
        for (int i = 0; i < pad; i++) fq.push_back(8'($urandom));
    endtask

    task automatic send_frame(input int gap_pct, input int err_at, input int rst_at);
        for (int i = 0; i < fq.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                rx_last  = 1'($urandom);
                rx_err   = 1'($urandom);
                tick();
            end
            rx_valid = 1'b1;
            rx_data  = fq[i];
            rx_last  = (i == fq.size() - 1);
            rx_err   = (i == err_at);
            rst      = (i == rst_at);
            tick();
            rst = 1'b0;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic wait_fall(input int f0, input int limit);
        int n;
        n = 0;
        while (falls == f0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (falls == f0) begin
            errors++;
            $display("FAIL hold_fall_timeout got=no_fall exp=fall_within_%0d", limit);
        end
    endtask

    initial begin
        int f0, r0, n1, kind, err_at, rst_at, q, sz;
        logic [47:0] da;
        logic [7:0] tmp;

        rst = 1'b1;
        idle(3);
        check("reset_hold", tx_pause_hold, 0);
        check("reset_quanta", pause_quanta, 0);
        check("reset_rcvd", pause_rcvd, 0);
        rst = 1'b0;
        idle(2);

        // Multicast PAUSE, Q=3 -> 192 hold cycles.
        f0 = falls; r0 = rcvd_cnt;
        build(MC_DA, 16'h8808, 16'h0001, 16'h0003, 0);
        send_frame(0, -1, -1);
        check("mc_rcvd_pulse", rcvd_cnt - r0, 1);
        check("mc_quanta", pause_quanta, 3);
        wait_fall(f0, 400);
        check("mc_hold_len", fall_n - last_rcvd_n, 192);

        // Station DA, padded, gappy, Q=16 -> 1024; then the same frame with an error.
        f0 = falls; r0 = rcvd_cnt;
        build(STATION, 16'h8808, 16'h0001, 16'h0010, 42);
        send_frame(30, -1, -1);
        check("st_rcvd_pulse", rcvd_cnt - r0, 1);
        wait_fall(f0, 1500);
        check("st_hold_len", fall_n - last_rcvd_n, 1024);
        r0 = rcvd_cnt;
        build(STATION, 16'h8808, 16'h0001, 16'h0020, 42);
        send_frame(30, 30, -1);
        idle(3);
        check("err_no_rcvd", rcvd_cnt - r0, 0);
        check("err_hold_low", tx_pause_hold, 0);
        check("err_quanta_kept", pause_quanta, 16);

        // Wrong ethertype, wrong opcode, runt.
        r0 = rcvd_cnt;
        build(MC_DA, 16'h0800, 16'h0001, 16'h0005, 4);
        send_frame(10, -1, -1);
        build(MC_DA, 16'h8808, 16'h0002, 16'h0005, 4);
        send_frame(10, -1, -1);
        build(MC_DA, 16'h8808, 16'h0001, 16'h0005, 0);
        void'(fq.pop_back());
        void'(fq.pop_back());
        send_frame(10, -1, -1);
        idle(3);
        check("bad_frames_no_rcvd", rcvd_cnt - r0, 0);
        check("bad_frames_hold_low", tx_pause_hold, 0);

        // Override: Q=100 then Q=2 after 500 cycles.
        f0 = falls;
        build(MC_DA, 16'h8808, 16'h0001, 16'd100, 0);
        send_frame(0, -1, -1);
        idle(500);
        build(MC_DA, 16'h8808, 16'h0001, 16'd2, 0);
        send_frame(0, -1, -1);
        wait_fall(f0, 400);
        check("override_hold_len", fall_n - last_rcvd_n, 128);

        // XON: Q=0 in the middle of a pause.
        build(STATION, 16'h8808, 16'h0001, 16'd50, 0);
        send_frame(0, -1, -1);
        idle(20);
        build(STATION, 16'h8808, 16'h0001, 16'd0, 0);
        send_frame(0, -1, -1);
        check("xon_hold_low", tx_pause_hold, 0);
        check("xon_quanta", pause_quanta, 0);

        // Reload coincident with expiry: Q=1 then Q=2 landing on the last hold cycle.
        idle(2);
        f0 = falls; r0 = rcvd_cnt;
        build(MC_DA, 16'h8808, 16'h0001, 16'd1, 0);
        send_frame(0, -1, -1);
        n1 = last_rcvd_n;
        idle(46);
        build(MC_DA, 16'h8808, 16'h0001, 16'd2, 0);
        send_frame(0, -1, -1);
        wait_fall(f0, 400);
        check("coinc_two_accepts", rcvd_cnt - r0, 2);
        check("coinc_single_fall", falls - f0, 1);
        check("coinc_hold_len", fall_n - n1, 192);

        // Reset mid-pause.
        build(MC_DA, 16'h8808, 16'h0001, 16'd20, 0);
        send_frame(0, -1, -1);
        idle(10);
        rst = 1'b1;
        tick();
        check("rst_mid_hold", tx_pause_hold, 0);
        check("rst_mid_quanta", pause_quanta, 0);
        check("rst_mid_rcvd", pause_rcvd, 0);
        rst = 1'b0;
        idle(2);

        // Randomized frames.
        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 5);
            q    = $urandom_range(0, 3);
            da   = ($urandom_range(0, 1) == 0) ? MC_DA : STATION;
            build(da, 16'h8808, 16'h0001, 16'(q), (kind == 5) ? $urandom_range(20, 46) : $urandom_range(0, 8));
            err_at = -1;
            if (kind == 2) begin
                sz = $urandom_range(0, 15);
                tmp = fq[sz] ^ (8'h01 << $urandom_range(0, 7));
                fq[sz] = tmp;
            end else if (kind == 3) begin
                sz = $urandom_range(1, 17);
                while (fq.size() > sz) void'(fq.pop_back());
            end else if (kind == 4) begin
                err_at = $urandom_range(0, fq.size() - 1);
            end
            rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(0, fq.size() - 1) : -1;
            $display("frame %0d kind=%0d q=%0d len=%0d err_at=%0d rst_at=%0d",
                     f, kind, q, fq.size(), err_at, rst_at);
            send_frame(20, err_at, rst_at);
            idle($urandom_range(0, 40));
        end
        idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
